// File: rtl/counter.sv
// ----------------------------------------------------------------------------
// counter
//
// Purpose:
//   Cascadable synchronous up-counter. The count advances by one on every
//   rising clock edge where the carry-in (count enable) is high. It wraps
//   from MODULUS-1 back to 0. The carry-out flags the terminal count
//   combinationally, so the cin of the next stage can be tied straight to
//   this cout.
//
// Parameters:
//   WIDTH    - width of the count output q, in bits
//   MODULUS  - count modulus; q runs 0..MODULUS-1 (legal range 2..2**WIDTH)
//
// Ports:
//   clock  in   1      system clock; all state changes on its rising edge
//   rst_n  in   1      asynchronous active-low reset; forces q to 0
//   cin    in   1      carry-in / count enable, sampled on the rising edge
//   cout   out  1      carry-out: cin high while q sits at MODULUS-1
//   q      out  WIDTH  current registered count value
// ----------------------------------------------------------------------------
module counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             cin,
    output logic             cout,
    output logic [WIDTH-1:0] q
);

    // The terminal value is compared explicitly. For moduli that are not a
    // power of two, the natural WIDTH-bit rollover would be wrong.
    localparam logic [WIDTH-1:0] TERMINAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             atTerminal;

    assign atTerminal = (count_q == TERMINAL);

    // Next-state logic: hold when disabled, wrap at the terminal count,
    // otherwise increment.
    always_comb begin
        count_d = count_q;
        if (cin) begin
            if (atTerminal) begin
                count_d = '0;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    // Count register. The reset acts immediately and does not wait for a
    // clock edge.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The carry-out is deliberately not registered. It is high in the same
    // cycle as the cin that causes the wrap, so a chained stage advances on
    // that same edge.
    assign cout = cin & atTerminal;
    assign q    = count_q;

endmodule

// File: tb/tb_counter.sv
// ----------------------------------------------------------------------------
// tb_counter
//
// Purpose:
//   Self-checking bench for counter. It builds two instances:
//     dutA - WIDTH=4, MODULUS=16 (natural binary wrap)
//     dutB - WIDTH=4, MODULUS=10 (explicit terminal compare)
//   The stimulus drives inputs 1 time unit after each rising edge. Each
//   expected {q, cout} is pushed into a scoreboard queue. A separate
//   monitor drains the queue at the following falling edge and compares.
//
// Ports: none (top-level bench).
// ----------------------------------------------------------------------------
module tb_counter;

    logic       clock;
    logic       rst_n;
    logic       cin;
    logic       cinB;
    logic       coutA;
    logic       coutB;
    logic [3:0] qA;
    logic [3:0] qB;

    int checks;
    int failures;

    typedef struct packed {
        logic        sel;
        logic [3:0]  q;
        logic        cout;
        logic [7:0]  testId;
        logic [15:0] step;
    } exp_t;

    exp_t sb[$];

    counter #(.WIDTH(4), .MODULUS(16)) dutA (
        .clock (clock),
        .rst_n (rst_n),
        .cin   (cin),
        .cout  (coutA),
        .q     (qA)
    );

    counter #(.WIDTH(4), .MODULUS(10)) dutB (
        .clock (clock),
        .rst_n (rst_n),
        .cin   (cinB),
        .cout  (coutB),
        .q     (qB)
    );

    // 10-unit clock period. Rising edges fall at 5, 15, 25, and so on.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Wait for the next rising edge, then drive the inputs just after it.
    task automatic applyStimulus(input logic rstnV, input logic cinV, input logic cinBV);
        @(posedge clock);
        #1;
        rst_n = rstnV;
        cin   = cinV;
        cinB  = cinBV;
    endtask

    task automatic expectA(input int qV, input logic coutV, input int testId, input int step);
        exp_t e;
        e.sel    = 1'b0;
        e.q      = 4'(qV);
        e.cout   = coutV;
        e.testId = 8'(testId);
        e.step   = 16'(step);
        sb.push_back(e);
    endtask

    task automatic expectB(input int qV, input logic coutV, input int testId, input int step);
        exp_t e;
        e.sel    = 1'b1;
        e.q      = 4'(qV);
        e.cout   = coutV;
        e.testId = 8'(testId);
        e.step   = 16'(step);
        sb.push_back(e);
    endtask

    // Compare one scoreboard entry against the instance it names.
    task automatic checkOutput(input exp_t e);
        logic [3:0] actQ;
        logic       actCout;
        actQ    = e.sel ? qB : qA;
        actCout = e.sel ? coutB : coutA;
        checks++;
        if (actQ !== e.q || actCout !== e.cout) begin
            failures++;
            $display("[TB] FAIL test%0d_step%0d_%s: got q=%0d cout=%0b, expected q=%0d cout=%0b",
                     e.testId, e.step, e.sel ? "mod10" : "mod16",
                     actQ, actCout, e.q, e.cout);
        end
    endtask

    // Monitor: every entry pushed during a cycle is checked at that
    // cycle's falling edge, well away from the active edge.
    always @(negedge clock) begin
        while (sb.size() > 0) begin
            checkOutput(sb.pop_front());
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        cin      = 1'b0;
        cinB     = 1'b0;

        // Reset state: both instances at 0, with cout low.
        applyStimulus(1'b0, 1'b0, 1'b0);
        expectA(0, 1'b0, 0, 0);
        expectB(0, 1'b0, 0, 0);

        // Test 1: count up to 7, then assert reset mid-cycle. q must clear
        // with no rising edge in between.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            expectA(i, 1'b0, 1, i);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        expectA(7, 1'b0, 1, 7);
        applyStimulus(1'b0, 1'b1, 1'b0);
        expectA(0, 1'b0, 1, 8);

        // Test 2: release reset and hold cin low for 5 clocks.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            expectA(0, 1'b0, 2, i);
        end

        // Test 3: a one-cycle cin pulse every 6 clocks, 5 times.
        for (int p = 1; p <= 5; p++) begin
            for (int k = 0; k < 6; k++) begin
                applyStimulus(1'b1, (k == 0), 1'b0);
                expectA((k == 0) ? p - 1 : p, 1'b0, 3, p * 10 + k);
            end
        end
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            expectA(5, 1'b0, 3, 100 + i);
        end

        // Test 4: reset, then cin high continuously from 0 up to the terminal.
        applyStimulus(1'b0, 1'b0, 1'b0);
        expectA(0, 1'b0, 4, 0);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            expectA(i, 1'b0, 4, 1 + i);
        end
        applyStimulus(1'b1, 1'b1, 1'b0);
        expectA(15, 1'b1, 4, 16);
        applyStimulus(1'b1, 1'b0, 1'b0);
        expectA(0, 1'b0, 4, 17);

        // Test 5: climb back to 15, then drop cin. cout must stay low and
        // q must hold at 15.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            expectA(i, 1'b0, 5, i);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            expectA(15, 1'b0, 5, 20 + i);
        end
        applyStimulus(1'b1, 1'b1, 1'b0);
        expectA(15, 1'b1, 5, 30);
        applyStimulus(1'b1, 1'b0, 1'b0);
        expectA(0, 1'b0, 5, 31);

        // Test 6: MODULUS=10 instance counts 0..9, with cout at 9, then wraps.
        applyStimulus(1'b0, 1'b0, 1'b0);
        expectB(0, 1'b0, 6, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            expectB(i, (i == 9), 6, 1 + i);
        end
        applyStimulus(1'b1, 1'b0, 1'b1);
        expectB(0, 1'b0, 6, 11);
        applyStimulus(1'b1, 1'b0, 1'b0);
        expectB(1, 1'b0, 6, 12);
        expectA(0, 1'b0, 6, 13);

        // Let the monitor drain the last entries. Anything still queued
        // counts as a failed check.
        @(posedge clock);
        @(posedge clock);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
